// File: rtl/file_path_pkg.sv
// rtl/file_path_pkg.sv - path mode type, prefix/suffix strings and byte lookup for save paths
package file_path_pkg;

  typedef enum logic {PATH_SRAM = 1'b0, PATH_IMAGE = 1'b1} path_mode_t;

  typedef enum logic [1:0] {ST_IDLE, ST_CONVERT, ST_STREAM} stream_state_t;

  localparam int SRAM_PREFIX_LEN = 26;
  localparam int IMG_PREFIX_LEN  = 25;
  localparam int SUFFIX_LEN      = 4;

  // String literals pack the first character into the most significant byte.
  localparam logic [8*SRAM_PREFIX_LEN-1:0] SRAM_PREFIX = "/Saves/camera/common/SRAM_";
  localparam logic [8*IMG_PREFIX_LEN-1:0]  IMG_PREFIX  = "/Saves/camera/common/IMG_";
  localparam logic [8*SUFFIX_LEN-1:0]      SAV_SUFFIX  = ".sav";
  localparam logic [8*SUFFIX_LEN-1:0]      BMP_SUFFIX  = ".bmp";

  function automatic logic [7:0] prefix_len(input path_mode_t m);
    return (m == PATH_SRAM) ? 8'(SRAM_PREFIX_LEN) : 8'(IMG_PREFIX_LEN);
  endfunction

  function automatic logic [7:0] affix_byte(input path_mode_t m, input logic suffix,
                                            input logic [7:0] off);
    logic [7:0] b;
    b = 8'h00;
    if (suffix) begin
      if (off < 8'(SUFFIX_LEN)) begin
        if (m == PATH_SRAM) b = SAV_SUFFIX[8*(SUFFIX_LEN-1-int'(off)) +: 8];
        else                b = BMP_SUFFIX[8*(SUFFIX_LEN-1-int'(off)) +: 8];
      end
    end else if (m == PATH_SRAM) begin
      if (off < 8'(SRAM_PREFIX_LEN)) b = SRAM_PREFIX[8*(SRAM_PREFIX_LEN-1-int'(off)) +: 8];
    end else begin
      if (off < 8'(IMG_PREFIX_LEN)) b = IMG_PREFIX[8*(IMG_PREFIX_LEN-1-int'(off)) +: 8];
    end
    return b;
  endfunction

endpackage

// File: rtl/bcd_serial.sv
// rtl/bcd_serial.sv - iterative double-dabble binary to BCD, one index bit per step
module bcd_serial #(
  parameter int INDEX_WIDTH = 10,
  parameter int DIGITS      = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load,
  input  logic                   step,
  input  logic [INDEX_WIDTH-1:0] index,
  output logic [DIGITS*4-1:0]    bcd,
  output logic                   done
);

  localparam int CW = $clog2(INDEX_WIDTH + 1);

  logic [INDEX_WIDTH-1:0] bin_q;
  logic [CW-1:0]          count;
  logic [DIGITS*4-1:0]    adj;

  always_comb begin
    adj = bcd;
    for (int d = 0; d < DIGITS; d++) begin
      if (bcd[4*d +: 4] >= 4'd5) adj[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
    end
  end

  // The top nibble's carry falls off the shift, leaving index mod 10**DIGITS.
  always_ff @(posedge clk) begin
    if (reset) begin
      bcd   <= '0;
      bin_q <= '0;
      count <= '0;
    end else if (load) begin
      bcd   <= '0;
      bin_q <= index;
      count <= CW'(INDEX_WIDTH);
    end else if (step && count != '0) begin
      bcd   <= {adj[DIGITS*4-2:0], bin_q[INDEX_WIDTH-1]};
      bin_q <= bin_q << 1;
      count <= count - 1'b1;
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/save_path_streamer.sv
// rtl/save_path_streamer.sv - builds "<prefix><index><suffix>" and streams it a byte at a time
module save_path_streamer
  import file_path_pkg::*;
#(
  parameter int INDEX_WIDTH = 10,
  parameter int DIGITS      = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [INDEX_WIDTH-1:0] save_index,
  input  logic                   mode,
  output logic                   busy,
  output logic [7:0]             path_length,
  output logic                   overflow,
  output logic [7:0]             out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last
);

  localparam int unsigned MAX_INDEX = 10**DIGITS - 1;
  localparam logic [7:0]  DIGITS_B  = 8'(DIGITS);

  stream_state_t       state;
  path_mode_t          mode_q;
  logic [7:0]          ptr;
  logic [DIGITS*4-1:0] bcd;
  logic                bcd_done;
  logic                bcd_load;
  logic                bcd_step;
  logic [7:0]          next_ptr;
  logic [7:0]          next_byte;
  logic [7:0]          pre_len;
  logic [7:0]          digit_off;
  logic [7:0]          suf_off;

  assign bcd_load = (state == ST_IDLE) && start;
  assign bcd_step = (state == ST_CONVERT);

  bcd_serial #(
    .INDEX_WIDTH(INDEX_WIDTH),
    .DIGITS     (DIGITS)
  ) u_bcd (
    .clk  (clk),
    .reset(reset),
    .load (bcd_load),
    .step (bcd_step),
    .index(save_index),
    .bcd  (bcd),
    .done (bcd_done)
  );

  // Byte for the pointer value that becomes current after the next transfer.
  always_comb begin
    next_ptr  = (state == ST_STREAM) ? ptr + 8'd1 : 8'd0;
    pre_len   = prefix_len(mode_q);
    digit_off = next_ptr - pre_len;
    suf_off   = digit_off - DIGITS_B;
    if (next_ptr < pre_len)
      next_byte = affix_byte(mode_q, 1'b0, next_ptr);
    else if (digit_off < DIGITS_B)
      next_byte = {4'h3, 4'(bcd >> (4 * (DIGITS_B - 8'd1 - digit_off)))};
    else
      next_byte = affix_byte(mode_q, 1'b1, suf_off);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      mode_q      <= PATH_SRAM;
      ptr         <= 8'd0;
      busy        <= 1'b0;
      path_length <= 8'd0;
      overflow    <= 1'b0;
      out_data    <= 8'd0;
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            mode_q      <= path_mode_t'(mode);
            overflow    <= 32'(save_index) > MAX_INDEX;
            path_length <= prefix_len(path_mode_t'(mode)) + DIGITS_B + 8'(SUFFIX_LEN);
            busy        <= 1'b1;
            state       <= ST_CONVERT;
          end
        end
        ST_CONVERT: begin
          if (bcd_done) begin
            ptr       <= 8'd0;
            out_data  <= next_byte;
            out_valid <= 1'b1;
            out_last  <= (path_length == 8'd1);
            state     <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (out_valid && out_ready) begin
            if (out_last) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              busy      <= 1'b0;
              state     <= ST_IDLE;
            end else begin
              ptr      <= next_ptr;
              out_data <= next_byte;
              out_last <= (next_ptr == path_length - 8'd1);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_save_path_streamer.sv
// tb/tb_save_path_streamer.sv - randomized self-checking bench for save_path_streamer
module tb_save_path_streamer;

  localparam int IW  = 10;
  localparam int DG  = 4;
  localparam int IW2 = 7;
  localparam int DG2 = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, start, mode, out_ready;
  logic [IW-1:0] save_index;
  logic          busy, overflow, out_valid, out_last;
  logic [7:0]    path_length, out_data;

  logic           start2, mode2, out_ready2;
  logic [IW2-1:0] save_index2;
  logic           busy2, overflow2, out_valid2, out_last2;
  logic [7:0]     path_length2, out_data2;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  logic       last_q[$];
  int         first_valid;

  save_path_streamer #(.INDEX_WIDTH(IW), .DIGITS(DG)) dut (
    .clk(clk), .reset(reset), .start(start), .save_index(save_index), .mode(mode),
    .busy(busy), .path_length(path_length), .overflow(overflow), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last)
  );

  save_path_streamer #(.INDEX_WIDTH(IW2), .DIGITS(DG2)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .save_index(save_index2), .mode(mode2),
    .busy(busy2), .path_length(path_length2), .overflow(overflow2), .out_data(out_data2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_last(out_last2)
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic void build_expected(input bit m, input int idx, input int digits);
    string pre, suf;
    int v, p;
    pre = m ? "/Saves/camera/common/IMG_" : "/Saves/camera/common/SRAM_";
    suf = m ? ".bmp" : ".sav";
    exp_q.delete();
    for (int i = 0; i < pre.len(); i++) exp_q.push_back(pre[i]);
    p = 1;
    repeat (digits) p = p * 10;
    v = idx % p;
    for (int d = digits - 1; d >= 0; d--) begin
      p = 1;
      repeat (d) p = p * 10;
      exp_q.push_back(8'(48 + (v / p) % 10));
    end
    for (int i = 0; i < suf.len(); i++) exp_q.push_back(suf[i]);
  endfunction

  task automatic verify(input string tag);
    check_eq({tag, "_count"}, got_q.size(), exp_q.size());
    for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
      check_eq($sformatf("%s_byte%0d", tag, k), int'(got_q[k]), int'(exp_q[k]));
      check_eq($sformatf("%s_last%0d", tag, k), int'(last_q[k]), int'(k == exp_q.size() - 1));
    end
  endtask

  task automatic request(input bit m, input int idx);
    @(negedge clk);
    start      = 1'b1;
    mode       = m;
    save_index = idx[IW-1:0];
    @(negedge clk);
    start = 1'b0;
    check_eq("busy_on_accept", int'(busy), 1);
    check_eq("path_length", int'(path_length), exp_q.size());
    check_eq("overflow", int'(overflow), int'(idx > 9999));
  endtask

  // Cycle c counts edges after the accepting edge; outputs are sampled on the falling edge.
  task automatic collect(input int ready_pct, input int poke_a, input int poke_b,
                         input bit start_on_last, input int abort_at);
    bit stalled, done, rdy, pl;
    logic [7:0] pd;
    int c;
    stalled = 0; done = 0; pl = 0; pd = 8'h00; c = 0;
    got_q.delete(); last_q.delete(); first_valid = -1;
    while (!done) begin
      @(negedge clk);
      c++;
      if (c > 400) begin
        check_eq("timeout", 1, 0);
        out_ready = 1'b0;
        done = 1;
      end else begin
        if (stalled) begin
          check_eq("stall_valid", int'(out_valid), 1);
          check_eq("stall_data", int'(out_data), int'(pd));
          check_eq("stall_last", int'(out_last), int'(pl));
        end
        if (out_valid && first_valid < 0) first_valid = c;
        if (abort_at >= 0 && got_q.size() == abort_at) begin
          out_ready = 1'b0;
          done = 1;
        end else begin
          start = (c == poke_a || c == poke_b);
          if (start) begin
            save_index = ~save_index;
            mode = ~mode;
          end
          rdy = ($urandom_range(99, 0) < ready_pct);
          out_ready = rdy;
          if (out_valid && rdy) begin
            got_q.push_back(out_data);
            last_q.push_back(out_last);
            check_eq("len_stable", int'(path_length), exp_q.size());
            if (out_last) begin
              done = 1;
              start = start_on_last;
            end
          end
          stalled = out_valid && !rdy;
          pd = out_data;
          pl = out_last;
        end
      end
    end
  endtask

  task automatic run2(input int idx);
    int c;
    bit done;
    build_expected(0, idx, DG2);
    @(negedge clk);
    start2 = 1'b1;
    save_index2 = idx[IW2-1:0];
    @(negedge clk);
    start2 = 1'b0;
    check_eq("d2_busy", int'(busy2), 1);
    check_eq("d2_path_length", int'(path_length2), exp_q.size());
    check_eq("d2_overflow", int'(overflow2), int'(idx > 99));
    got_q.delete(); last_q.delete(); first_valid = -1;
    c = 0; done = 0;
    while (!done) begin
      @(negedge clk);
      c++;
      if (c > 200) begin
        check_eq("d2_timeout", 1, 0);
        done = 1;
      end else if (out_valid2) begin
        if (first_valid < 0) first_valid = c;
        got_q.push_back(out_data2);
        last_q.push_back(out_last2);
        if (out_last2) done = 1;
      end
    end
    verify($sformatf("d2_idx%0d", idx));
    check_eq("d2_latency", first_valid, IW2 + 1);
  endtask

  initial begin
    int m, idx, pct;
    reset = 1'b1; start = 1'b0; mode = 1'b0; save_index = '0; out_ready = 1'b0;
    start2 = 1'b0; mode2 = 1'b0; save_index2 = '0; out_ready2 = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_valid", int'(out_valid), 0);
    check_eq("rst_last", int'(out_last), 0);
    check_eq("rst_data", int'(out_data), 0);
    check_eq("rst_overflow", int'(overflow), 0);
    check_eq("rst_path_length", int'(path_length), 0);
    reset = 1'b0;

    build_expected(0, 7, DG);
    request(0, 7);
    collect(100, -1, -1, 0, -1);
    verify("t1");
    check_eq("t1_latency", first_valid, IW + 1);

    build_expected(1, 1023, DG);
    request(1, 1023);
    collect(100, -1, -1, 0, -1);
    verify("t2");

    build_expected(0, 7, DG);
    request(0, 7);
    collect(50, -1, -1, 0, -1);
    verify("t4");

    build_expected(0, 321, DG);
    request(0, 321);
    collect(100, 3, 20, 1, -1);
    verify("t5");
    @(negedge clk);
    start = 1'b0;
    check_eq("t5_idle_busy", int'(busy), 0);
    check_eq("t5_idle_valid", int'(out_valid), 0);
    @(negedge clk);
    check_eq("t5_idle_busy2", int'(busy), 0);
    build_expected(1, 42, DG);
    request(1, 42);
    collect(100, -1, -1, 0, -1);
    verify("t5b");

    build_expected(0, 999, DG);
    request(0, 999);
    collect(100, -1, -1, 0, 10);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_eq("t6_valid", int'(out_valid), 0);
    check_eq("t6_busy", int'(busy), 0);
    build_expected(0, 5, DG);
    request(0, 5);
    collect(100, -1, -1, 0, -1);
    verify("t6");

    repeat (6) begin
      m   = int'($urandom_range(1, 0));
      idx = int'($urandom_range(1023, 0));
      pct = ($urandom_range(2, 0) == 0) ? 100 : int'($urandom_range(80, 30));
      build_expected(m[0], idx, DG);
      request(m[0], idx);
      collect(pct, -1, -1, 0, -1);
      verify($sformatf("rnd_m%0d_i%0d", m, idx));
    end

    run2(123);
    run2(99);
    run2(int'($urandom_range(127, 0)));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
